// File: rtl/fx_mul_pipe.sv
// Pipelined signed fixed-point multiplier with selectable rounding and overflow handling.
// Operands are registered, multiplied, rounded, then range-limited into the output register.
`timescale 1ns/1ps
module fx_mul_pipe #(
  parameter int W    = 16,
  parameter int FRAC = 15,
  parameter int RND  = 0,
  parameter int SAT  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic [15:0]  ovf_cnt,
  input  logic         cnt_clr
);

  localparam int PW = 2 * W;
  localparam int RW = 2 * W + 1;

  localparam logic signed [RW-1:0] ONE  = RW'(1);
  localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC - 1);
  localparam logic signed [RW-1:0] MAXV = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         YMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         YMIN = {1'b1, {(W-1){1'b0}}};

  logic                 adv;
  logic                 v1_reg, v2_reg, v3_reg;
  logic signed [W-1:0]  a_reg, b_reg;
  logic signed [PW-1:0] p_reg, p_next;
  logic signed [RW-1:0] r_reg, r_next;
  logic signed [RW-1:0] p_ext, odd_bit, sum_next;
  logic                 hi_next, lo_next, ovf_next;
  logic [W-1:0]         y_next;

  // Every stage moves in lockstep; a stalled output freezes the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign p_next = PW'(a_reg) * PW'(b_reg);

  always_comb begin
    p_ext    = RW'(p_reg);
    odd_bit  = {{(RW-1){1'b0}}, p_reg[FRAC]};
    sum_next = p_ext;
    case (RND)
      1:       sum_next = p_ext + HALF;
      2:       sum_next = p_ext + HALF - ONE + odd_bit;
      default: sum_next = p_ext;
    endcase
    r_next = sum_next >>> FRAC;
  end

  always_comb begin
    hi_next  = r_reg > MAXV;
    lo_next  = r_reg < MINV;
    ovf_next = hi_next || lo_next;
    y_next   = r_reg[W-1:0];
    if (SAT != 0) begin
      if (hi_next)      y_next = YMAX;
      else if (lo_next) y_next = YMIN;
    end
  end

  // Data registers only load on a valid entry; valid bits alone mark bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
      r_reg     <= '0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      v1_reg    <= in_valid;
      v2_reg    <= v1_reg;
      v3_reg    <= v2_reg;
      out_valid <= v3_reg;
      if (in_valid) begin
        a_reg <= a;
        b_reg <= b;
      end
      if (v1_reg) p_reg <= p_next;
      if (v2_reg) r_reg <= r_next;
      if (v3_reg) begin
        y   <= y_next;
        ovf <= ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Bench for fx_mul_pipe: four parameter variants share one stimulus stream and are
// scored against an arithmetic model of the product, rounding and range rules.
`timescale 1ns/1ps
module tb_fx_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  in_ready_v, out_valid_v, ovf_v;
  logic [15:0] y_v [4];
  logic [15:0] cnt_v [4];

  int          n_checks = 0;
  int          n_errs = 0;
  int          hs_total = 0;
  bit          quiet = 1'b0;
  logic [31:0] pend_q [$];
  int          exp_cnt [4];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_y [4];
  logic [16:0] mres [4];
  logic [31:0] pr;
  bit          hs, had;

  always #5 clk = ~clk;

  // Variants: 0..2 = RND 0/1/2 with clamping, 3 = RND 0 with wrap.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    fx_mul_pipe #(
      .W(16), .FRAC(15), .RND((gi == 3) ? 0 : gi), .SAT((gi == 3) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_v[gi]),
      .a(a), .b(b),
      .out_valid(out_valid_v[gi]), .out_ready(out_ready),
      .y(y_v[gi]), .ovf(ovf_v[gi]),
      .ovf_cnt(cnt_v[gi]), .cnt_clr(cnt_clr)
    );
  end

  function automatic int rnd_of(input int i);
    return (i == 3) ? 0 : i;
  endfunction

  function automatic int sat_of(input int i);
    return (i == 3) ? 0 : 1;
  endfunction

  // Real-valued product scaled by 2^15, floored, then rounded by remainder inspection.
  function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input int rnd, input int sat);
    longint p, q, rem;
    logic [15:0] yv;
    logic ov;
    p = longint'($signed(av)) * longint'($signed(bv));
    q = p / 32768;
    if (p < 0 && (p % 32768) != 0) q = q - 1;
    rem = p - q * 32768;
    if (rnd == 1 && rem >= 16384) q = q + 1;
    else if (rnd == 2 && (rem > 16384 || (rem == 16384 && (q % 2) != 0))) q = q + 1;
    ov = (q > 32767) || (q < -32768);
    if (!ov || sat == 0) yv = q[15:0];
    else if (q > 0)      yv = 16'h7FFF;
    else                 yv = 16'h8000;
    return {ov, yv};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom % 6)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will commit.
  always @(negedge clk) begin : mon
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("in_ready%0d", i), in_ready_v[i], !out_valid_v[i] || out_ready);
        check($sformatf("cnt%0d", i), cnt_v[i], exp_cnt[i]);
        if (prev_stall) begin
          check($sformatf("stall_y%0d", i), y_v[i], prev_y[i]);
          check($sformatf("stall_ov%0d", i), out_valid_v[i], 1);
        end
        if (pend_q.size() == 0) check($sformatf("bubble%0d", i), out_valid_v[i], 0);
      end
      hs  = out_valid_v[0] && out_ready;
      had = 1'b0;
      if (hs && pend_q.size() != 0) begin
        had = 1'b1;
        pr  = pend_q.pop_front();
        hs_total++;
        for (int i = 0; i < 4; i++) begin
          mres[i] = model(pr[31:16], pr[15:0], rnd_of(i), sat_of(i));
          check($sformatf("y%0d", i), y_v[i], mres[i][15:0]);
          check($sformatf("ovf%0d", i), ovf_v[i], mres[i][16]);
          check($sformatf("ov%0d", i), out_valid_v[i], 1);
        end
        if (!quiet)
          $display("xfer %0d a=%h b=%h y=%h %h %h %h ovf=%b cnt=%0d",
                   hs_total, pr[31:16], pr[15:0], y_v[0], y_v[1], y_v[2], y_v[3],
                   ovf_v, cnt_v[0]);
      end
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr) exp_cnt[i] = 0;
        else if (had && mres[i][16] && exp_cnt[i] < 65535) exp_cnt[i] = exp_cnt[i] + 1;
      end
      if (in_valid && in_ready_v[0]) pend_q.push_back({a, b});
      prev_stall = out_valid_v[0] && !out_ready;
      for (int i = 0; i < 4; i++) prev_y[i] = y_v[i];
    end
  end

  // One pair through an empty pipe; checks latency and per-variant results.
  task automatic send_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [63:0] ey, input logic [3:0] eo, input bit clr);
    int e;
    e = 0;
    in_valid = 1'b1; a = av; b = bv; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid_v[0] && e < 10) begin
      @(posedge clk); #1;
      e++;
    end
    check({tag, "_lat"}, e, 3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_y%0d", tag, i), y_v[i], ey[16*i +: 16]);
      check($sformatf("%s_ovf%0d", tag, i), ovf_v[i], eo[i]);
    end
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  // mode 0: random traffic, 1: six pairs with a 4-cycle output stall, 2: overflow fill.
  task automatic run(input int n, input int mode, input int budget);
    int sent, k, hs0;
    bit acc;
    sent = 0; k = 0; hs0 = hs_total;
    while (sent < n && k < budget) begin
      case (mode)
        0: begin
          in_valid  = ($urandom % 4) != 0;
          a = pick(); b = pick();
          out_ready = ($urandom % 3) != 0;
        end
        1: begin
          in_valid  = 1'b1;
          a = 16'(16'h1000 * (sent + 1)); b = 16'h2000;
          out_ready = !(k >= 4 && k < 8);
        end
        default: begin
          in_valid = 1'b1; a = 16'h8000; b = 16'h8000; out_ready = 1'b1;
        end
      endcase
      @(negedge clk);
      acc = in_valid && in_ready_v[0];
      if (mode == 1 && k >= 4 && k < 8) check("bp_in_ready", in_ready_v[0], 0);
      @(posedge clk); #1;
      if (acc) sent++;
      k++;
    end
    check("budget", sent, n);
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (pend_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", pend_q.size(), 0);
    if (mode == 1) check("bp_results", hs_total - hs0, n);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_ov%0d", tag, i), out_valid_v[i], 0);
      check($sformatf("%s_y%0d", tag, i), y_v[i], 0);
      check($sformatf("%s_ovf%0d", tag, i), ovf_v[i], 0);
      check($sformatf("%s_cnt%0d", tag, i), cnt_v[i], 0);
      check($sformatf("%s_rdy%0d", tag, i), in_ready_v[i], 1);
    end
  endtask

  initial begin
    int seen;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    #3;
    check_reset_state("rst");
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    check("rel_rdy", in_ready_v[0], 1);
    @(posedge clk); #1;

    send_one("half",  16'h4000, 16'h4000, {16'h2000, 16'h2000, 16'h2000, 16'h2000}, 4'b0000, 1'b0);
    send_one("mneg",  16'h8000, 16'h8000, {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("mneg_cnt%0d", i), cnt_v[i], 1);
    send_one("rnd1",  16'h0001, 16'h4000, {16'h0000, 16'h0000, 16'h0001, 16'h0000}, 4'b0000, 1'b0);
    send_one("rnd3",  16'h0003, 16'h4000, {16'h0001, 16'h0002, 16'h0002, 16'h0001}, 4'b0000, 1'b0);
    send_one("rndm1", 16'hFFFF, 16'h4000, {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}, 4'b0000, 1'b0);
    send_one("clr",   16'h8000, 16'h8000, {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("clr_cnt%0d", i), cnt_v[i], 0);

    run(6, 1, 40);
    run(800, 0, 4000);

    // Stall three pairs in flight, then reset asynchronously mid-cycle.
    send_one("pre",   16'h8000, 16'h8000, {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'b1111, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = pick(); b = pick();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("flight_ov", out_valid_v[0], 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pend_q.delete();
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    #1;
    check_reset_state("mid");
    @(posedge clk); #2;
    rst_n = 1'b1;
    check("rel2_rdy", in_ready_v[0], 1);
    out_ready = 1'b1;
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (out_valid_v != 4'b0000) seen++;
    end
    check("stale", seen, 0);

    quiet = 1'b1;
    run(65536, 2, 66000);
    quiet = 1'b0;
    $display("fill done cnt=%h %h %h %h", cnt_v[0], cnt_v[1], cnt_v[2], cnt_v[3]);
    for (int i = 0; i < 4; i++) check($sformatf("sat_cnt%0d", i), cnt_v[i], 16'hFFFF);
    run(1, 2, 10);
    for (int i = 0; i < 4; i++) check($sformatf("stick_cnt%0d", i), cnt_v[i], 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_errs, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
